// File: rtl/fwd_hazard_unit_if.sv
// rtl/fwd_hazard_unit_if.sv - ID-stage request and forwarding/stall response bundle for fwd_hazard_unit
interface fwd_hazard_unit_if #(
   parameter int REG_AW  = 5,
   parameter int NUM_SRC = 3,
   parameter int DEPTH   = 3,
   parameter int CNT_W   = 16
);
   localparam int SEL_W = $clog2(DEPTH + 1);

   logic                      id_valid;
   logic [NUM_SRC*REG_AW-1:0] id_src;
   logic [NUM_SRC-1:0]        id_src_used;
   logic [REG_AW-1:0]         id_dest;
   logic                      id_wb_en;
   logic                      id_mem_read;
   logic                      flush;
   logic                      hold;
   logic [NUM_SRC*SEL_W-1:0]  fwd_sel;
   logic                      stall;
   logic [CNT_W-1:0]          stall_cnt;

   modport master (
      output id_valid, id_src, id_src_used, id_dest, id_wb_en, id_mem_read, flush, hold,
      input  fwd_sel, stall, stall_cnt
   );

   modport slave (
      input  id_valid, id_src, id_src_used, id_dest, id_wb_en, id_mem_read, flush, hold,
      output fwd_sel, stall, stall_cnt
   );
endinterface

// File: rtl/fwd_hazard_unit.sv
// rtl/fwd_hazard_unit.sv - forwarding select and load-use stall unit; FWD_PATH_EN enables forwarding, else full interlock
module fwd_hazard_unit #(
   parameter int REG_AW  = 5,
   parameter int NUM_SRC = 3,
   parameter int DEPTH   = 3,
   parameter int CNT_W   = 16
) (
   input  logic                clk,
   input  logic                rst,
   fwd_hazard_unit_if.slave    bus
);
   localparam int SEL_W = $clog2(DEPTH + 1);

   logic [DEPTH:1]     r_valid;
   logic [DEPTH:1]     r_wb_en;
   logic [REG_AW-1:0]  r_dest [1:DEPTH];
   logic [CNT_W-1:0]   r_stall_cnt;

   logic [DEPTH:1]     w_live;
   logic               w_stall;
   logic               w_accept;
   logic [NUM_SRC*SEL_W-1:0] w_fwd_sel;

`ifdef FWD_PATH_EN
   // Only the youngest entry's load flag can ever cause a stall, so it is not carried down the pipe.
   logic               r_e1_mem_read;
   logic [NUM_SRC-1:0] w_hit1;

   always_comb begin
      w_fwd_sel = '0;
      w_hit1    = '0;
      for (int k = 1; k <= DEPTH; k++)
         w_live[k] = r_valid[k] & r_wb_en[k] & (r_dest[k] != '0);
      for (int i = 0; i < NUM_SRC; i++) begin
         // Scan oldest to youngest so the youngest producer overwrites the select.
         for (int k = DEPTH; k >= 1; k--) begin
            if (bus.id_valid && bus.id_src_used[i] && w_live[k] &&
                (bus.id_src[i*REG_AW +: REG_AW] == r_dest[k])) begin
               w_fwd_sel[i*SEL_W +: SEL_W] = SEL_W'(k);
               if (k == 1) w_hit1[i] = 1'b1;
            end
         end
      end
      w_stall  = (|w_hit1) & r_e1_mem_read & ~bus.flush;
      w_accept = bus.id_valid & ~bus.flush & ~w_stall;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_e1_mem_read <= 1'b0;
      else if (!bus.hold)
         r_e1_mem_read <= w_accept & bus.id_mem_read;
   end

   assign bus.fwd_sel = w_fwd_sel;
`else
   logic w_any_hit;

   always_comb begin
      w_any_hit = 1'b0;
      w_fwd_sel = '0;
      for (int k = 1; k <= DEPTH; k++)
         w_live[k] = r_valid[k] & r_wb_en[k] & (r_dest[k] != '0);
      for (int i = 0; i < NUM_SRC; i++)
         for (int k = 1; k <= DEPTH; k++)
            if (bus.id_valid && bus.id_src_used[i] && w_live[k] &&
                (bus.id_src[i*REG_AW +: REG_AW] == r_dest[k]))
               w_any_hit = 1'b1;
      w_stall  = w_any_hit & ~bus.flush;
      w_accept = bus.id_valid & ~bus.flush & ~w_stall;
   end

   assign bus.fwd_sel = w_fwd_sel;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid     <= '0;
         r_wb_en     <= '0;
         r_stall_cnt <= '0;
         for (int k = 1; k <= DEPTH; k++) r_dest[k] <= '0;
      end else if (!bus.hold) begin
         for (int k = 2; k <= DEPTH; k++) begin
            r_valid[k] <= r_valid[k-1];
            r_wb_en[k] <= r_wb_en[k-1];
            r_dest[k]  <= r_dest[k-1];
         end
         r_valid[1] <= w_accept;
         r_wb_en[1] <= w_accept & bus.id_wb_en;
         r_dest[1]  <= w_accept ? bus.id_dest : '0;
         if (w_stall && (r_stall_cnt != {CNT_W{1'b1}}))
            r_stall_cnt <= r_stall_cnt + 1'b1;
      end
   end

   assign bus.stall     = w_stall;
   assign bus.stall_cnt = r_stall_cnt;
endmodule
